// File: rtl/poly_coeff_mac_modq.sv
// Accumulates signed truncated products into one polynomial coefficient, reduces it mod q = 2^LOG_Q,
// and hands it downstream with a valid/ready handshake before accepting the next coefficient's terms.
module poly_coeff_mac_modq #(
   parameter int N     = 677,
   parameter int LOG_Q = 11,
   parameter int W     = 16
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic [W-1:0]     p_din,
   input  logic             p_valid,
   input  logic             p_last,
   output logic             p_ready,
   output logic [LOG_Q-1:0] coef_dout,
   output logic [9:0]       coef_idx,
   output logic             coef_valid,
   input  logic             coef_ready,
   output logic             poly_done,
   output logic             term_ovf
);

   // Handshakes: a beat or coefficient transfers on a rising edge where valid and ready are both
   // high; the sender holds its data stable while valid is high and ready is low.

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t         state;
   logic [W-1:0]   acc;
   logic [CW-1:0]  term_cnt;
   logic [W-1:0]   sum;
   logic           accept;
   logic           at_cap;
   logic           last_idx;

   assign p_ready  = (state == ACC);
   assign accept   = p_valid && p_ready;
   assign sum      = acc + p_din;
   assign at_cap   = (term_cnt == CW'(N - 1));
   assign last_idx = (coef_idx == 10'(N - 1));

   // Since q divides 2^W, the low LOG_Q bits of the wrapped sum are already the residue mod q.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state      <= ACC;
         acc        <= '0;
         term_cnt   <= '0;
         coef_idx   <= '0;
         coef_dout  <= '0;
         coef_valid <= 1'b0;
         poly_done  <= 1'b0;
         term_ovf   <= 1'b0;
      end else begin
         poly_done <= 1'b0;
         case (state)
            ACC: begin
               if (accept) begin
                  if (p_last || at_cap) begin
                     coef_dout  <= sum[LOG_Q-1:0];
                     coef_valid <= 1'b1;
                     acc        <= '0;
                     term_cnt   <= '0;
                     state      <= HOLD;
                     if (!p_last) begin
                        term_ovf <= 1'b1;
                     end
                  end else begin
                     acc      <= sum;
                     term_cnt <= term_cnt + CW'(1);
                  end
               end
            end
            HOLD: begin
               if (coef_ready) begin
                  coef_valid <= 1'b0;
                  state      <= ACC;
                  coef_idx   <= last_idx ? 10'd0 : coef_idx + 10'd1;
                  poly_done  <= last_idx;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule
